// File: rtl/osr_ctrl_pkg.sv
// Shared PIO OSR definitions: controller state encoding and the 0-means-32 field decode.
package osr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REFILL    = 2'd1,
    ST_WAIT_FIFO = 2'd2
  } osr_state_t;

  typedef enum logic {
    OP_OUT  = 1'b0,
    OP_PULL = 1'b1
  } pend_op_t;

  localparam logic [5:0] FULL_BITS = 6'd32;

  // Shift/threshold fields encode a full 32-bit word as 0.
  function automatic logic [5:0] bits_decode(input logic [4:0] v);
    return (v == 5'd0) ? FULL_BITS : {1'b0, v};
  endfunction

endpackage

// File: rtl/osr_ctrl_if.sv
// TX FIFO read port and OSR datapath controls; master is the sequencing controller.
interface osr_ctrl_if;
  logic        fifo_empty;
  logic [31:0] fifo_dout;
  logic        fifo_pull;
  logic        osr_set;
  logic [31:0] osr_din;
  logic        osr_do_shift;
  logic [4:0]  osr_shift;
  logic [5:0]  shift_count;

  modport master (
    input  fifo_empty, fifo_dout, shift_count,
    output fifo_pull, osr_set, osr_din, osr_do_shift, osr_shift
  );

  modport slave (
    output fifo_empty, fifo_dout, shift_count,
    input  fifo_pull, osr_set, osr_din, osr_do_shift, osr_shift
  );
endinterface

// File: rtl/osr_ctrl.sv
// OSR sequencer: picks load (FIFO/X), shift or hold each enabled cycle and raises stall.
// Latency: decisions combinational; autopulled OUT costs one extra active cycle.
// Backpressure: empty FIFO on a needed load stalls the PC until data shows ahead.
module osr_ctrl
  import osr_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        penable,
  input  logic        auto_pull,
  input  logic [4:0]  pull_thresh,
  input  logic        exec_out,
  input  logic [4:0]  out_count,
  input  logic        exec_pull,
  input  logic        pull_block,
  input  logic        pull_ifempty,
  input  logic [31:0] x_value,
  output logic        stall,
  osr_ctrl_if.master  bus
);

  osr_state_t  state, state_nxt;
  pend_op_t    pend, pend_nxt;
  logic        act;
  logic        reached;
  logic        pop, set, do_shift;
  logic [31:0] din;
  logic [4:0]  shift_amt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      pend  <= OP_OUT;
    end else if (penable) begin
      state <= state_nxt;
      pend  <= pend_nxt;
    end
  end

  assign act     = penable & ~reset;
  assign reached = auto_pull & (bus.shift_count >= bits_decode(pull_thresh));

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    pop       = 1'b0;
    set       = 1'b0;
    din       = 32'd0;
    do_shift  = 1'b0;
    shift_amt = 5'd0;
    stall     = 1'b0;
    if (act) begin
      case (state)
        ST_IDLE: begin
          if (exec_pull) begin
            // IfEmpty PULL is a no-op until the OSR has drained to threshold.
            if (pull_ifempty & auto_pull & ~reached) begin
              stall = 1'b0;
            end else if (~bus.fifo_empty) begin
              pop = 1'b1;
              set = 1'b1;
              din = bus.fifo_dout;
            end else if (pull_block) begin
              stall     = 1'b1;
              pend_nxt  = OP_PULL;
              state_nxt = ST_WAIT_FIFO;
            end else begin
              set = 1'b1;
              din = x_value;
            end
          end else if (exec_out) begin
            if (~reached) begin
              do_shift  = 1'b1;
              shift_amt = out_count;
            end else if (~bus.fifo_empty) begin
              pop       = 1'b1;
              set       = 1'b1;
              din       = bus.fifo_dout;
              stall     = 1'b1;
              state_nxt = ST_REFILL;
            end else begin
              stall     = 1'b1;
              pend_nxt  = OP_OUT;
              state_nxt = ST_WAIT_FIFO;
            end
          end else if (reached & ~bus.fifo_empty) begin
            pop = 1'b1;
            set = 1'b1;
            din = bus.fifo_dout;
          end
        end
        ST_REFILL: begin
          do_shift  = 1'b1;
          shift_amt = out_count;
          state_nxt = ST_IDLE;
        end
        ST_WAIT_FIFO: begin
          if (bus.fifo_empty) begin
            stall = 1'b1;
          end else begin
            pop = 1'b1;
            set = 1'b1;
            din = bus.fifo_dout;
            if (pend == OP_OUT) begin
              stall     = 1'b1;
              state_nxt = ST_REFILL;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.fifo_pull    = pop;
  assign bus.osr_set      = set;
  assign bus.osr_din      = din;
  assign bus.osr_do_shift = do_shift;
  assign bus.osr_shift    = shift_amt;

endmodule
